cb_doutb_map: RTL and testbench

- Read-side counterpart of the cache-bank port-B write mapper.
- Takes the L-lane word read from cache bank port B (CB_doutb) and maps it onto the X input lanes of the systolic array (RSA).
- Steers lanes by direction code (POS/NEG/NEW) and re-times them for the array.
- Re-timing has two parts: it absorbs the BRAM read latency, then applies the per-lane diagonal skew the systolic array needs.

---
 rtl/cb_doutb_map_pkg.sv | 38 +++
 rtl/rsa_lane_skew.sv | 32 +++
 rtl/cb_doutb_map.sv | 140 ++++++++++++++
 tb/tb_cb_doutb_map.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cb_doutb_map_pkg.sv
// Shared definitions for the cache-bank port-B mappers (write and read side):
// direction and group codes plus the lane-steering helpers.
package cb_doutb_map_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  localparam logic [2:0] CBb_IDLE = 3'b000;
  localparam logic [2:0] CBb_A    = 3'b001;
  localparam logic [2:0] CBb_C    = 3'b001;

  // True when output lane `lane` carries mapped data for direction `dir`.
  function automatic logic lane_used(input dir_e dir, input int lane, input int lanes);
    case (dir)
      DIR_POS, DIR_NEG: return 1'b1;
      DIR_NEW:          return lane < lanes / 2;
      default:          return 1'b0;
    endcase
  endfunction

  // Source cache-bank lane feeding output lane `lane`; only meaningful when lane_used().
  function automatic int lane_src(input dir_e dir, input logic l_k_0, input int lane,
                                  input int lanes);
    case (dir)
      DIR_NEG: return lanes - 1 - lane;
      DIR_NEW: return (l_k_0 == DIR_NEW_1) ? lane : lane + lanes / 2;
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/rsa_lane_skew.sv
// Triangular delay line: lane i is delayed by i registers so the systolic
// array sees its diagonal wavefront. Synchronous active-high clear.
module rsa_lane_skew #(
  parameter int X = 4,
  parameter int W = 33
) (
  input  logic           clk,
  input  logic           sys_rst,
  input  logic [X*W-1:0] in_bus,
  output logic [X*W-1:0] out_bus
);

  for (genvar i = 0; i < X; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign out_bus[W-1:0] = in_bus[W-1:0];
    end else begin : g_dly
      logic [W-1:0] dly [i];

      always_ff @(posedge clk) begin
        if (sys_rst) begin
          for (int s = 0; s < i; s++) dly[s] <= '0;
        end else begin
          dly[0] <= in_bus[i*W +: W];
          for (int s = 1; s < i; s++) dly[s] <= dly[s-1];
        end
      end

      assign out_bus[i*W +: W] = dly[i-1];
    end
  end

endmodule

// File: rtl/cb_doutb_map.sv
// Read-side cache-bank port-B mapper: delays the select to meet the BRAM read
// data, steers lanes by direction, then skews them onto the RSA X inputs.
module cb_doutb_map
  import cb_doutb_map_pkg::*;
#(
  parameter int X               = 4,
  parameter int L               = 4,
  parameter int RSA_DW          = 32,
  parameter int CB_DOUTB_SEL_DW = 5,
  parameter int RD_DELAY        = 2
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         rd_en,
  input  logic [CB_DOUTB_SEL_DW-1:0]   CB_doutb_sel,
  input  logic                         l_k_0,
  input  logic signed [L*RSA_DW-1:0]   CB_doutb,
  output logic signed [X*RSA_DW-1:0]   A_CB_doutb,
  output logic [X-1:0]                 A_CB_vld
);

  localparam int GRP_DW = CB_DOUTB_SEL_DW - 2;
  localparam int W      = RSA_DW + 1;

  if (X != L) begin : g_bad_lanes
    $error("cb_doutb_map: X must equal L");
  end
  if (RD_DELAY < 1 || RD_DELAY > 4) begin : g_bad_delay
    $error("cb_doutb_map: RD_DELAY must be 1..4");
  end

  // Select pipeline, aligned with the BRAM read latency.
  logic [CB_DOUTB_SEL_DW-1:0] sel_q [RD_DELAY];
  logic                       lk_q  [RD_DELAY];
  logic                       vld_q [RD_DELAY];

  // NOTE: these stage arrays are tiny flop banks, not RAM, so clearing them on
  // reset is cheap and is what guarantees in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int s = 0; s < RD_DELAY; s++) begin
        sel_q[s] <= '0;
        lk_q[s]  <= 1'b0;
        vld_q[s] <= 1'b0;
      end
    end else begin
      sel_q[0] <= CB_doutb_sel;
      lk_q[0]  <= l_k_0;
      vld_q[0] <= rd_en;
      for (int s = 1; s < RD_DELAY; s++) begin
        sel_q[s] <= sel_q[s-1];
        lk_q[s]  <= lk_q[s-1];
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  logic [GRP_DW-1:0] rd_grp;
  dir_e              rd_dir;
  logic              rd_lk;
  logic              rd_vld;

  assign rd_grp = sel_q[RD_DELAY-1][CB_DOUTB_SEL_DW-1:2];
  assign rd_dir = dir_e'(sel_q[RD_DELAY-1][1:0]);
  assign rd_lk  = lk_q[RD_DELAY-1];
  assign rd_vld = vld_q[RD_DELAY-1];

  logic [RSA_DW-1:0] cb_lane [L];
  logic [RSA_DW-1:0] map_d   [X];
  logic              map_v   [X];
  logic [RSA_DW-1:0] map_dq  [X];
  logic              map_vq  [X];
  int                src;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    src = 0;
    for (int j = 0; j < L; j++) cb_lane[j] = CB_doutb[j*RSA_DW +: RSA_DW];
    for (int i = 0; i < X; i++) begin
      map_d[i] = '0;
      map_v[i] = 1'b0;
    end
    if (rd_vld && rd_grp == GRP_DW'(CBb_A)) begin
      for (int i = 0; i < X; i++) begin
        if (lane_used(rd_dir, i, L)) begin
          src      = lane_src(rd_dir, rd_lk, i, L);
          map_v[i] = 1'b1;
          for (int j = 0; j < L; j++) begin
            if (j == src) map_d[i] = cb_lane[j];
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < X; i++) begin
        map_dq[i] <= '0;
        map_vq[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < X; i++) begin
        map_dq[i] <= map_d[i];
        map_vq[i] <= map_v[i];
      end
    end
  end

  logic [X*W-1:0] skew_in;
  logic [X*W-1:0] skew_out;

  always_comb begin
    skew_in = '0;
    for (int i = 0; i < X; i++) skew_in[i*W +: W] = {map_vq[i], map_dq[i]};
  end

  rsa_lane_skew #(
    .X (X),
    .W (W)
  ) u_skew (
    .clk     (clk),
    .sys_rst (sys_rst),
    .in_bus  (skew_in),
    .out_bus (skew_out)
  );

  always_comb begin
    A_CB_doutb = '0;
    A_CB_vld   = '0;
    for (int i = 0; i < X; i++) begin
      A_CB_doutb[i*RSA_DW +: RSA_DW] = skew_out[i*W +: RSA_DW];
      A_CB_vld[i]                    = skew_out[i*W + RSA_DW];
    end
  end

endmodule

// File: tb/tb_cb_doutb_map.sv
// Directed bench for cb_doutb_map: a per-cycle stimulus table with
// hand-placed expected lane values, compared on every cycle for every lane.
module tb_cb_doutb_map;

  localparam int N = 50;
  localparam int B = 32;  // start of the reset-mid-flight scenario

  logic         clk = 1'b0;
  logic         sys_rst;
  logic         rd_en;
  logic [4:0]   CB_doutb_sel;
  logic         l_k_0;
  logic [127:0] CB_doutb;
  logic [127:0] A_CB_doutb;
  logic [3:0]   A_CB_vld;

  cb_doutb_map dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .rd_en        (rd_en),
    .CB_doutb_sel (CB_doutb_sel),
    .l_k_0        (l_k_0),
    .CB_doutb     (CB_doutb),
    .A_CB_doutb   (A_CB_doutb),
    .A_CB_vld     (A_CB_vld)
  );

  always #5 clk = ~clk;

  logic        st_rd  [N];
  logic [4:0]  st_sel [N];
  logic        st_lk  [N];
  logic        st_rst [N];
  logic [31:0] st_din [N][4];
  logic [31:0] ex_d   [N][4];
  logic        ex_v   [N][4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int t, input logic [4:0] sel, input logic lk);
    st_rd[t]  = 1'b1;
    st_sel[t] = sel;
    st_lk[t]  = lk;
  endtask

  task automatic want(input int c, input int lane, input logic [31:0] v);
    ex_d[c][lane] = v;
    ex_v[c][lane] = 1'b1;
  endtask

  initial begin
    // Background: no reads, non-zero garbage on the read bus every cycle.
    for (int c = 0; c < N; c++) begin
      st_rd[c]  = 1'b0;
      st_sel[c] = 5'b00101;
      st_lk[c]  = 1'b0;
      st_rst[c] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        st_din[c][j] = 32'hDEAD_0000 + 32'(c * 16 + j);
        ex_d[c][j]   = '0;
        ex_v[c][j]   = 1'b0;
      end
    end

    // POS at 0: bus lanes {1,2,3,4} at 2 -> lane i = i+1 at 3+i.
    issue(0, 5'b00101, 1'b0);
    for (int j = 0; j < 4; j++) st_din[2][j] = 32'(j + 1);
    want(3, 0, 1); want(4, 1, 2); want(5, 2, 3); want(6, 3, 4);

    // NEG at 1: same data at 3 -> lane i = 4-i at 4+i.
    issue(1, 5'b00110, 1'b0);
    for (int j = 0; j < 4; j++) st_din[3][j] = 32'(j + 1);
    want(4, 0, 4); want(5, 1, 3); want(6, 2, 2); want(7, 3, 1);

    // NEW l_k_0=1 at 2: {A,B,C,D} -> lanes 0,1 = A,B.
    issue(2, 5'b00111, 1'b1);
    st_din[4][0] = 32'hA; st_din[4][1] = 32'hB; st_din[4][2] = 32'hC; st_din[4][3] = 32'hD;
    want(5, 0, 32'hA); want(6, 1, 32'hB);

    // NEW l_k_0=0 at 3: {E0..E3} -> lanes 0,1 = E2,E3.
    issue(3, 5'b00111, 1'b0);
    for (int j = 0; j < 4; j++) st_din[5][j] = 32'hE0 + 32'(j);
    want(6, 0, 32'hE2); want(7, 1, 32'hE3);

    // IDLE direction and a foreign group: nothing comes out.
    issue(4, 5'b00100, 1'b0);
    issue(5, 5'b10101, 1'b0);

    // Eight back-to-back POS reads; lane 3 carries negative values.
    for (int k = 0; k < 8; k++) begin
      issue(10 + k, 5'b00101, 1'b0);
      for (int j = 0; j < 3; j++) begin
        st_din[12 + k][j] = 32'((k << 8) | j);
        want(13 + k + j, j, 32'((k << 8) | j));
      end
      st_din[12 + k][3] = 32'hFFFF_FFFF - 32'(k);
      want(16 + k, 3, 32'hFFFF_FFFF - 32'(k));
    end

    // Three reads, reset during B+4, fresh NEG read at B+6.
    issue(B, 5'b00101, 1'b0);
    issue(B + 1, 5'b00101, 1'b0);
    issue(B + 2, 5'b00101, 1'b0);
    for (int j = 0; j < 4; j++) begin
      st_din[B + 2][j] = 32'h5000 + 32'(j);
      st_din[B + 3][j] = 32'h6000 + 32'(j);
      st_din[B + 4][j] = 32'h6800 + 32'(j);
      st_din[B + 8][j] = 32'h7000 + 32'(j);
    end
    want(B + 3, 0, 32'h5000);
    want(B + 4, 1, 32'h5001);
    want(B + 4, 0, 32'h6000);
    st_rst[B + 4] = 1'b1;
    issue(B + 6, 5'b00110, 1'b0);
    for (int i = 0; i < 4; i++) want(B + 9 + i, i, 32'h7003 - 32'(i));

    // Reset phase.
    sys_rst      = 1'b1;
    rd_en        = 1'b0;
    CB_doutb_sel = '0;
    l_k_0        = 1'b0;
    CB_doutb     = {4{32'h1234_5678}};
    repeat (3) @(negedge clk);
    check("reset_data", A_CB_doutb[31:0] | A_CB_doutb[63:32] | A_CB_doutb[95:64]
                        | A_CB_doutb[127:96], 32'h0);
    check("reset_vld", 32'(A_CB_vld), 32'h0);
    sys_rst = 1'b0;

    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("c%0d_lane%0d_data", c, i), A_CB_doutb[i*32 +: 32], ex_d[c][i]);
        check($sformatf("c%0d_lane%0d_vld", c, i), 32'(A_CB_vld[i]), 32'(ex_v[c][i]));
      end
      sys_rst      = st_rst[c];
      rd_en        = st_rd[c];
      CB_doutb_sel = st_sel[c];
      l_k_0        = st_lk[c];
      CB_doutb     = {st_din[c][3], st_din[c][2], st_din[c][1], st_din[c][0]};
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
